// File: rtl/ram_ctrl.sv
// ram_ctrl: data-memory responder for the pipeline. Accepts one read or write
// per transaction, runs a multi-cycle access on an asynchronous SRAM and
// returns a one-cycle ack. All SRAM controls and the bus drive enable are
// registered, so they are decoded from the next state and never glitch.
module ram_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_rw
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WSETUP = 3'd2,
        WPULSE = 3'd3,
        WHOLD  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [DATA_W-1:0]  wdata_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               drive_r;
    logic               en_r;
    logic               oe_r;
    logic               rw_r;
    logic               ack_r;
    logic               drive_nxt_s;
    logic               en_nxt_s;
    logic               oe_nxt_s;
    logic               rw_nxt_s;
    logic               ack_nxt_s;
    logic               accept_s;
    logic               last_read_s;

    // A request is taken only while idle; a write beats a simultaneous read.
    assign accept_s    = (state_r == IDLE) && (req_rd || req_wr);
    // Final READ cycle: the SRAM data is sampled on the edge that ends it.
    assign last_read_s = (state_r == READ) && (cnt_r == {CNT_W{1'b0}});

    // State and phase counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_wr) begin
                    next_state_s = WSETUP;
                end else if (req_rd) begin
                    next_state_s = READ;
                    cnt_nxt_s    = RD_LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = DONE;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WSETUP: begin
                next_state_s = WPULSE;
                cnt_nxt_s    = WR_LOAD;
            end
            WPULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = WHOLD;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WHOLD:   next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state, so the registered pins line up with the state they belong to.
    always_comb begin
        en_nxt_s    = 1'b1;
        oe_nxt_s    = 1'b1;
        rw_nxt_s    = 1'b1;
        drive_nxt_s = 1'b0;
        ack_nxt_s   = 1'b0;
        case (next_state_s)
            IDLE: begin
                en_nxt_s = 1'b1;
            end
            READ: begin
                en_nxt_s = 1'b0;
                oe_nxt_s = 1'b0;
            end
            WSETUP: begin
                en_nxt_s    = 1'b0;
                drive_nxt_s = 1'b1;
            end
            WPULSE: begin
                en_nxt_s    = 1'b0;
                rw_nxt_s    = 1'b0;
                drive_nxt_s = 1'b1;
            end
            WHOLD: begin
                en_nxt_s    = 1'b0;
                drive_nxt_s = 1'b1;
            end
            DONE: begin
                ack_nxt_s = 1'b1;
            end
            default: begin
                en_nxt_s = 1'b1;
            end
        endcase
    end

    // SRAM control pins, bus enable and ack; reset parks the SRAM immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r    <= 1'b1;
            oe_r    <= 1'b1;
            rw_r    <= 1'b1;
            drive_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            en_r    <= en_nxt_s;
            oe_r    <= oe_nxt_s;
            rw_r    <= rw_nxt_s;
            drive_r <= drive_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    // Address/write-data latch at acceptance and read-data capture at the end of READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
            if (last_read_s) begin
                rdata_r <= ram_data;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // The controller only drives the bus in the write states, where ram_oe is high.
    assign ram_data = drive_r ? wdata_r : {DATA_W{1'bz}};

    assign busy     = accept_s || ((state_r != IDLE) && (state_r != DONE));
    assign rdata    = rdata_r;
    assign ack      = ack_r;
    assign ram_addr = addr_r;
    assign ram_en   = en_r;
    assign ram_oe   = oe_r;
    assign ram_rw   = rw_r;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: an SRAM model on the bus, a transaction-level
// reference (expected memory contents, expected read data, expected
// latencies and strobe lengths) and randomized read/write traffic.
module tb_ram_ctrl;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int RDC = 2;
    localparam int WRC = 2;
    localparam logic [DW-1:0] FLOAT = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_rd;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_en;
    logic          ram_oe;
    logic          ram_rw;

    int n_checks = 0;
    int n_errors = 0;

    // Undriven bus floats high so a released bus is observable.
    pullup bus_pu (ram_data);

    ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata),
        .ack(ack), .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_rw(ram_rw)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives on enable+output-enable, stores while the write strobe is low.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    assign ram_data = (!ram_en && !ram_oe && ram_rw) ? sram[ram_addr] : {DW{1'bz}};

    // SRAM write: capture the bus on every clock edge seen with the strobe low.
    always @(posedge clk) begin
        if (rst && !ram_en && !ram_rw) sram[ram_addr] <= ram_data;
    end

    // Reference model: memory contents and the last completed read value.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ref_rdata;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        else return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transaction; called right after a falling edge, issues in this cycle (cycle 0).
    task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat_exp;
        int got_lat;
        int busy_cnt;
        int oe_cnt;
        int rw_cnt;
        int en_cnt;
        int drv_cnt;
        int addr_bad;
        logic [DW-1:0] bus_done;
        logic [DW-1:0] rd_at_ack;
        lat_exp  = wr ? (WRC + 3) : (RDC + 1);
        got_lat  = 0;
        drv_cnt  = 0;
        addr_bad = 0;
        bus_done = 16'h0000;
        rd_at_ack = 16'h0000;
        req_wr = wr; req_rd = rd; req_addr = a; req_wdata = d;
        #1;
        busy_cnt = int'(busy);
        oe_cnt   = int'(!ram_oe);
        rw_cnt   = int'(!ram_rw);
        en_cnt   = int'(!ram_en);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            oe_cnt   += int'(!ram_oe);
            rw_cnt   += int'(!ram_rw);
            en_cnt   += int'(!ram_en);
            if (ram_addr !== a) addr_bad++;
            if (ram_data === d) drv_cnt++;
            if (ack) begin
                got_lat   = k;
                bus_done  = ram_data;
                rd_at_ack = rdata;
                break;
            end
        end
        req_wr = 1'b0; req_rd = 1'b0;
        if (wr) ref_mem[int'(a)] = d;
        else ref_rdata = ref_rd(a);
        chk("latency",   32'(got_lat),  32'(lat_exp));
        chk("busy_cyc",  32'(busy_cnt), 32'(lat_exp));
        chk("oe_cyc",    32'(oe_cnt),   wr ? 32'd0 : 32'(RDC));
        chk("rw_cyc",    32'(rw_cnt),   wr ? 32'(WRC) : 32'd0);
        chk("en_cyc",    32'(en_cnt),   32'(lat_exp - 1));
        chk("addr_hold", 32'(addr_bad), 32'd0);
        chk("bus_done",  32'(bus_done), 32'(FLOAT));
        chk("rdata",     32'(rd_at_ack), 32'(ref_rdata));
        if (wr) chk("wr_drive", 32'(drv_cnt), 32'(WRC + 2));
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 32'd0);
    endtask

    // Watchdog: a hung run still reports before stopping.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_v;
        int op;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0000;
        sram[18'h00123]  = 16'hBEEF;
        ref_mem[32'h123] = 16'hBEEF;
        ref_rdata = 16'h0000;

        // Reset held with a pending read: nothing moves, no ack.
        rst = 1'b0; req_rd = 1'b1; req_wr = 1'b0;
        req_addr = 18'h00123; req_wdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack",   32'(ack),      32'd0);
            chk("rst_rdata", 32'(rdata),    32'd0);
            chk("rst_addr",  32'(ram_addr), 32'd0);
            chk("rst_ctl",   32'({ram_en, ram_oe, ram_rw}), 32'h7);
            chk("rst_bus",   32'(ram_data), 32'(FLOAT));
        end
        rst = 1'b1;
        run_txn(1'b0, 1'b1, 18'h00123, 16'h0000);

        // Write to the top address, then read it back.
        run_txn(1'b1, 1'b0, 18'h3FFFF, 16'h1234);
        run_txn(1'b0, 1'b1, 18'h3FFFF, 16'h0000);

        // Simultaneous read and write: write only, rdata unchanged.
        run_txn(1'b1, 1'b1, 18'h00050, 16'h7E7E);
        run_txn(1'b0, 1'b1, 18'h00050, 16'h0000);

        // Back-to-back write then read of the same word.
        run_txn(1'b1, 1'b0, 18'h00001, 16'hA5A5);
        run_txn(1'b0, 1'b1, 18'h00001, 16'h0000);

        // Randomized traffic over a small address window with random gaps.
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(2, 0));
            case ($urandom_range(2, 0))
                0:       ra = 18'h3FFFF;
                1:       ra = 18'h00123;
                default: ra = AW'($urandom_range(31, 0));
            endcase
            rd_v = DW'($urandom_range(32'hFFFE, 0));
            if (op == 0) run_txn(1'b0, 1'b1, ra, 16'h0000);
            else if (op == 1) run_txn(1'b1, 1'b0, ra, rd_v);
            else run_txn(1'b1, 1'b1, ra, rd_v);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // Reset in the middle of the write pulse.
        req_wr = 1'b1; req_rd = 1'b0; req_addr = 18'h2AAAA; req_wdata = 16'h5A5A;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rw_low", 32'(ram_rw), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_ctl",   32'({ram_en, ram_oe, ram_rw}), 32'h7);
        chk("mid_bus",   32'(ram_data), 32'(FLOAT));
        chk("mid_addr",  32'(ram_addr), 32'd0);
        chk("mid_rdata", 32'(rdata),    32'd0);
        req_wr = 1'b0;
        ref_rdata = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_ack", 32'(ack), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 1'b1, 18'h3FFFF, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
